sort_frame_io: RTL and testbench

SORT_FRAME_IO -- requirements
Module: sort_frame_io

---
 rtl/sort_frame_io.sv | 145 ++++++++++++++
 tb/tb_sort_frame_io.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_frame_io.sv
// Frame buffer around an external sort network: collects a frame,
// pads short frames, hands it to the network, then streams the sorted words.
module sort_frame_io #(
    parameter int    DATA_WIDTH = 64,
    parameter int    DATA_CNT   = 16,
    parameter string COM_STYLE  = "UP",
    parameter int    SORT_LAT   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_last,
    output logic [DATA_CNT*DATA_WIDTH-1:0] net_data,
    output logic                           net_start,
    input  logic [DATA_CNT*DATA_WIDTH-1:0] net_result,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic                           m_last,
    output logic                           len_err
);

    localparam int CW = $clog2(DATA_CNT + 1);
    localparam int IW = $clog2(DATA_CNT);
    localparam int LW = $clog2(SORT_LAT + 1);

    localparam logic [CW-1:0] LAST_SLOT = CW'(DATA_CNT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DATA_CNT);
    localparam logic [LW-1:0] LAT_END   = LW'(SORT_LAT - 1);

    // Pads must sort behind every real word so they land at the high end
    localparam logic [DATA_WIDTH-1:0] PAD =
        (COM_STYLE == "DOWN") ? '0 : '1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] n_words_q, n_words_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          len_err_d;
    logic          wr_en;
    logic          cap;

    logic [DATA_CNT-1:0][DATA_WIDTH-1:0] frame_q;
    logic [DATA_CNT-1:0][DATA_WIDTH-1:0] obuf_q;

    assign s_ready   = (state_q == FILL) && !rst;
    assign wr_en     = s_valid && s_ready;
    assign net_data  = frame_q;
    assign net_start = (state_q == SORT) && (lat_q == '0);
    assign m_valid   = (state_q == DRAIN);
    assign m_data    = obuf_q[rd_cnt_q[IW-1:0]];
    assign m_last    = m_valid && (rd_cnt_q == n_words_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        n_words_d = n_words_q;
        lat_d     = lat_q;
        len_err_d = 1'b0;
        cap       = 1'b0;
        unique case (state_q)
            FILL: begin
                lat_d = '0;
                if (wr_en) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == LAST_SLOT) begin
                        n_words_d = FULL_CNT;
                        state_d   = SORT;
                        len_err_d = !s_last;
                    end else if (s_last) begin
                        n_words_d = wr_cnt_q + 1'b1;
                        state_d   = SORT;
                    end
                end
            end
            SORT: begin
                if (lat_q == LAT_END) begin
                    cap      = 1'b1;
                    rd_cnt_d = '0;
                    state_d  = DRAIN;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (m_last) begin
                        rd_cnt_d = '0;
                        wr_cnt_d = '0;
                        state_d  = FILL;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            n_words_q <= '0;
            lat_q     <= '0;
            len_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            n_words_q <= n_words_d;
            lat_q     <= lat_d;
            len_err   <= len_err_d;
        end
    end

    // Datapath storage: no reset, only written under clean control
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_CNT; i++) begin
                if (CW'(i) == wr_cnt_q) begin
                    frame_q[i] <= s_data;
                end else if (s_last && (CW'(i) > wr_cnt_q)) begin
                    frame_q[i] <= PAD;
                end
            end
        end
        if (cap) begin
            obuf_q <= net_result;
        end
    end

endmodule

// File: tb/tb_sort_frame_io.sv
// Directed bench for sort_frame_io: 4 lanes of 8 bits, ascending
// network model, frame/pad/len_err/stall/back-to-back/reset scenarios.
module tb_sort_frame_io;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [31:0] net_data;
    logic        net_start;
    logic [31:0] net_result;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        len_err;

    int vecs;
    int errs;

    sort_frame_io #(
        .DATA_WIDTH(8),
        .DATA_CNT  (4),
        .COM_STYLE ("UP"),
        .SORT_LAT  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .net_data  (net_data),
        .net_start (net_start),
        .net_result(net_result),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sort4(input logic [31:0] v);
        logic [7:0] a [4];
        logic [7:0] t;
        for (int i = 0; i < 4; i++) a[i] = v[i*8 +: 8];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j];
                    a[j] = a[j+1];
                    a[j+1] = t;
                end
        return {a[3], a[2], a[1], a[0]};
    endfunction

    // Network model: ascending sort, one register stage; result valid in
    // the second SORT cycle, where the DUT captures it.
    always_ff @(posedge clk) net_result <= sort4(net_data);

    task automatic push(input logic [7:0] d, input logic last);
        logic ok;
        logic done;
        done = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int i = 0; i < 60 && !done; i++) begin
            ok = s_ready;
            @(negedge clk);
            if (ok) done = 1'b1;
        end
        if (!done) begin
            vecs++;
            errs++;
            $display("FAIL push_timeout data=%02h s_ready=%b", d, s_ready);
        end
    endtask

    task automatic wait_valid();
        int c;
        c = 0;
        while (m_valid !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        vecs++;
        if (m_valid !== 1'b1) begin
            errs++;
            $display("FAIL wait_valid m_valid=%b want 1", m_valid);
        end
    endtask

    // Consume cnt words of an n-word frame; pat gives m_ready per cycle
    task automatic drain(input logic [31:0] exp, input int n,
                         input int cnt, input logic [7:0] pat);
        int k;
        int c;
        logic [7:0] ew;
        logic el;
        k = 0;
        c = 0;
        while (k < cnt && c < 40) begin
            m_ready = (c < 8) ? pat[c] : 1'b1;
            #1;
            ew = exp[k*8 +: 8];
            el = (k == n - 1);
            vecs++;
            if (m_valid !== 1'b1 || m_data !== ew ||
                m_last !== el || s_ready !== 1'b0) begin
                errs++;
                $display("FAIL drain_word%0d got v=%b d=%02h l=%b sr=%b want v=1 d=%02h l=%b sr=0",
                         k, m_valid, m_data, m_last, s_ready, ew, el);
            end
            @(negedge clk);
            if (m_ready) k++;
            c++;
        end
        m_ready = 1'b0;
        if (k < cnt) begin
            vecs++;
            errs++;
            $display("FAIL drain_timeout got %0d words want %0d", k, cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
            net_start !== 1'b0 || len_err !== 1'b0) begin
            errs++;
            $display("FAIL reset_state sr=%b mv=%b ml=%b ns=%b le=%b want all 0",
                     s_ready, m_valid, m_last, net_start, len_err);
        end
        rst = 1'b0;
        #1;
        vecs++;
        if (s_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_release s_ready=%b want 1", s_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        push(8'h05, 1'b0);
        push(8'h03, 1'b0);
        push(8'h09, 1'b0);
        push(8'h01, 1'b1);
        s_valid = 1'b0;
        vecs++;
        if (net_start !== 1'b1 || len_err !== 1'b0 ||
            net_data !== 32'h01090305 || s_ready !== 1'b0) begin
            errs++;
            $display("FAIL full_sort_entry ns=%b le=%b nd=%08h sr=%b want 1 0 01090305 0",
                     net_start, len_err, net_data, s_ready);
        end
        @(negedge clk);
        vecs++;
        if (net_start !== 1'b0 || m_valid !== 1'b0 || len_err !== 1'b0) begin
            errs++;
            $display("FAIL full_sort_wait ns=%b mv=%b le=%b want 0 0 0",
                     net_start, m_valid, len_err);
        end
        @(negedge clk);
        drain(32'h09050301, 4, 4, 8'hFF);
        vecs++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errs++;
            $display("FAIL full_done mv=%b sr=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_short_frame();
        push(8'h07, 1'b0);
        push(8'h02, 1'b1);
        s_valid = 1'b0;
        vecs++;
        if (net_start !== 1'b1 || net_data !== 32'hFFFF0207) begin
            errs++;
            $display("FAIL short_pad ns=%b nd=%08h want 1 FFFF0207",
                     net_start, net_data);
        end
        wait_valid();
        drain(32'h00000702, 2, 2, 8'hFF);
        vecs++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errs++;
            $display("FAIL short_no_pads mv=%b sr=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_len_err();
        push(8'h04, 1'b0);
        push(8'h04, 1'b0);
        push(8'h00, 1'b0);
        push(8'hFF, 1'b0);
        s_valid = 1'b0;
        vecs++;
        if (len_err !== 1'b1 || net_start !== 1'b1) begin
            errs++;
            $display("FAIL len_err_pulse le=%b ns=%b want 1 1", len_err, net_start);
        end
        @(negedge clk);
        vecs++;
        if (len_err !== 1'b0) begin
            errs++;
            $display("FAIL len_err_single le=%b want 0", len_err);
        end
        wait_valid();
        drain(32'hFF040400, 4, 4, 8'hFF);
        vecs++;
        if (m_valid !== 1'b0 || len_err !== 1'b0) begin
            errs++;
            $display("FAIL len_err_done mv=%b le=%b want 0 0", m_valid, len_err);
        end
    endtask

    task automatic test_stall();
        push(8'h05, 1'b0);
        push(8'h03, 1'b0);
        push(8'h09, 1'b0);
        push(8'h01, 1'b1);
        s_valid = 1'b0;
        wait_valid();
        drain(32'h09050301, 4, 4, 8'hE9);
        vecs++;
        if (m_valid !== 1'b0) begin
            errs++;
            $display("FAIL stall_extra_word mv=%b want 0", m_valid);
        end
    endtask

    task automatic test_back_to_back();
        push(8'h06, 1'b0);
        push(8'h05, 1'b0);
        push(8'h04, 1'b0);
        push(8'h03, 1'b1);
        s_data = 8'h0A;
        s_last = 1'b0;
        vecs++;
        if (s_ready !== 1'b0 || net_start !== 1'b1) begin
            errs++;
            $display("FAIL b2b_sort0 sr=%b ns=%b want 0 1", s_ready, net_start);
        end
        @(negedge clk);
        vecs++;
        if (s_ready !== 1'b0) begin
            errs++;
            $display("FAIL b2b_sort1 sr=%b want 0", s_ready);
        end
        @(negedge clk);
        drain(32'h06050403, 4, 4, 8'hFF);
        push(8'h0A, 1'b0);
        push(8'h0B, 1'b0);
        push(8'h0C, 1'b0);
        push(8'h0D, 1'b1);
        s_valid = 1'b0;
        wait_valid();
        drain(32'h0D0C0B0A, 4, 4, 8'hFF);
        vecs++;
        if (m_valid !== 1'b0) begin
            errs++;
            $display("FAIL b2b_done mv=%b want 0", m_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        push(8'h05, 1'b0);
        push(8'h03, 1'b0);
        push(8'h09, 1'b0);
        push(8'h01, 1'b1);
        s_valid = 1'b0;
        wait_valid();
        drain(32'h09050301, 4, 2, 8'hFF);
        rst = 1'b1;
        #1;
        vecs++;
        if (s_ready !== 1'b0) begin
            errs++;
            $display("FAIL mid_rst_ready sr=%b want 0", s_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vecs++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 ||
            net_start !== 1'b0 || s_ready !== 1'b1) begin
            errs++;
            $display("FAIL mid_rst_after mv=%b ml=%b ns=%b sr=%b want 0 0 0 1",
                     m_valid, m_last, net_start, s_ready);
        end
        @(negedge clk);
        push(8'h08, 1'b0);
        push(8'h06, 1'b1);
        s_valid = 1'b0;
        wait_valid();
        drain(32'h00000806, 2, 2, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (m_valid !== 1'b0) begin
                errs++;
                $display("FAIL mid_rst_stale cycle%0d mv=%b want 0", i, m_valid);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vecs    = 0;
        errs    = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_short_frame();
        test_len_err();
        test_stall();
        test_back_to_back();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
